// File: rtl/shift_sub_divider.sv
// -----------------------------------------------------------------------------
// shift_sub_divider
//
// Iterative restoring unsigned divider. It produces one quotient bit per clock
// using shift-and-subtract. Two cases finish in one cycle instead of WIDTH
// cycles: division by zero, and dividend < divisor. A result stays on the
// outputs after completion until the next request is accepted.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     request; taken only while in_ready is high
//   dividend     unsigned numerator, sampled on accept
//   divisor      unsigned denominator, sampled on accept
//   in_ready     high in IDLE and DONE, low while iterating
//   quotient     result quotient (all ones on divide-by-zero)
//   remainder    result remainder (the dividend on divide-by-zero)
//   div_by_zero  qualifies the current result
//   out_valid    one-cycle completion pulse
// -----------------------------------------------------------------------------
module shift_sub_divider #(
    parameter int WIDTH_LOG = 5,
    parameter int WIDTH     = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             in_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             out_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH_LOG:0] LAST_ITER = (WIDTH_LOG + 1)'(WIDTH - 1);

    state_t state;
    state_t state_next;

    // The running remainder is always below the divisor, so WIDTH bits hold
    // it. Only the shifted trial value needs the extra bit.
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quo_reg;
    logic [WIDTH-1:0]   dvs_reg;
    logic [WIDTH_LOG:0] counter;
    logic               dbz_reg;

    logic             accept;
    logic             fast_path;
    logic             last_iter;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign accept    = in_valid && (state != CALC);
    assign fast_path = (divisor == '0) || (dividend < divisor);
    assign last_iter = (counter == LAST_ITER);

    // Shift the next dividend bit out of quo_reg into the partial remainder.
    assign trial = {rem_reg, quo_reg[WIDTH-1]};
    assign fits  = (trial >= {1'b0, dvs_reg});
    // When the trial fits, the difference is below the divisor. Modulo-2^WIDTH
    // arithmetic on the low bits therefore gives the exact result.
    assign diff  = trial[WIDTH-1:0] - dvs_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fast_path ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A request arriving in DONE is taken immediately, so
                // back-to-back operations have no idle bubble.
                if (accept) begin
                    state_next = fast_path ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_reg <= '0;
            quo_reg <= '0;
            dvs_reg <= '0;
            counter <= '0;
            dbz_reg <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quo_reg <= '1;
                rem_reg <= dividend;
                dbz_reg <= 1'b1;
            end else if (dividend < divisor) begin
                quo_reg <= '0;
                rem_reg <= dividend;
                dbz_reg <= 1'b0;
            end else begin
                quo_reg <= dividend;
                rem_reg <= '0;
                dvs_reg <= divisor;
                counter <= '0;
                dbz_reg <= 1'b0;
            end
        end else if (state == CALC) begin
            rem_reg <= fits ? diff : trial[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], fits};
            counter <= counter + 1'b1;
        end
    end

    assign quotient    = quo_reg;
    assign remainder   = rem_reg;
    assign div_by_zero = dbz_reg;
    assign out_valid   = (state == DONE);
    assign in_ready    = (state != CALC);

endmodule

// File: tb/tb_shift_sub_divider.sv
// -----------------------------------------------------------------------------
// tb_shift_sub_divider
//
// Bench for shift_sub_divider at the default 32-bit width. Expected results
// are queued when a request is issued and popped when out_valid appears.
// Cycle numbering: cycle 1 is the first cycle after the accept edge.
// -----------------------------------------------------------------------------
module tb_shift_sub_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         out_valid;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } res_t;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    shift_sub_divider #(.WIDTH_LOG(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .dividend    (dividend),
        .divisor     (divisor),
        .in_ready    (in_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .out_valid   (out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic res_t model(input logic [W-1:0] n, input logic [W-1:0] d);
        res_t m;
        if (d == 0) begin
            m.q = '1;
            m.r = n;
            m.dbz = 1'b1;
        end else begin
            m.q = n / d;
            m.r = n % d;
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    function automatic res_t observed();
        res_t o;
        o.q = quotient;
        o.r = remainder;
        o.dbz = div_by_zero;
        return o;
    endfunction

    // Called at posedge+1; the request is taken on the following edge and
    // the task returns at posedge+1 of cycle 1.
    task automatic accept_req(input logic [W-1:0] n, input logic [W-1:0] d, input bit track);
        in_valid = 1'b1;
        dividend = n;
        divisor  = d;
        if (track) sb.push_back(model(n, d));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Returns the cycle index in which out_valid is seen (-1 on timeout) and
    // the number of cycles that in_ready was low before that.
    task automatic wait_result(output int cyc, output int busy);
        cyc = 1;
        busy = 0;
        while (out_valid !== 1'b1 && cyc <= 100) begin
            if (in_ready === 1'b0) busy++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (out_valid !== 1'b1) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({quotient, remainder, div_by_zero, out_valid, in_ready} !== {{(2*W){1'b0}}, 3'b001}) begin
            n_err++;
            $display("FAIL reset_state: got q=%0h r=%0h dbz=%0b ov=%0b ir=%0b, want 0 0 0 0 1",
                     quotient, remainder, div_by_zero, out_valid, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_path();
        int cyc, busy;
        res_t got, want;
        accept_req(100, 7, 1'b1);
        wait_result(cyc, busy);
        n_cmp++;
        if (busy != W) begin
            n_err++;
            $display("FAIL full_busy: in_ready low %0d cycles, want %0d", busy, W);
        end
        n_cmp++;
        if (cyc != W + 1) begin
            n_err++;
            $display("FAIL full_latency: out_valid in cycle %0d, want %0d", cyc, W + 1);
        end
        got = observed();
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL full_result: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=%0b",
                     got.q, got.r, got.dbz, want.q, want.r, want.dbz);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, observed()} !== {1'b0, want}) begin
            n_err++;
            $display("FAIL full_hold: got ov=%0b q=%0d r=%0d dbz=%0b, want ov=0 q=%0d r=%0d dbz=%0b",
                     out_valid, quotient, remainder, div_by_zero, want.q, want.r, want.dbz);
        end
    endtask

    task automatic test_div_by_zero();
        int cyc, busy;
        res_t got, want;
        accept_req(32'h1234, 0, 1'b1);
        wait_result(cyc, busy);
        n_cmp++;
        if (cyc != 1) begin
            n_err++;
            $display("FAIL dbz_latency: out_valid in cycle %0d, want 1", cyc);
        end
        got = observed();
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL dbz_result: got q=%0h r=%0h dbz=%0b, want q=%0h r=%0h dbz=%0b",
                     got.q, got.r, got.dbz, want.q, want.r, want.dbz);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_single_pulse: out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_fast_path();
        logic [W-1:0] tn[4] = '{32'd5, 32'd0, 32'd0, 32'd6};
        logic [W-1:0] td[4] = '{32'd9, 32'd5, 32'd0, 32'd7};
        int cyc, busy;
        res_t got, want;
        for (int i = 0; i < 4; i++) begin
            accept_req(tn[i], td[i], 1'b1);
            wait_result(cyc, busy);
            n_cmp++;
            if (cyc != 1) begin
                n_err++;
                $display("FAIL fast_latency[%0d]: out_valid in cycle %0d, want 1", i, cyc);
            end
            got = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL fast_result[%0d]: got q=%0h r=%0h dbz=%0b, want q=%0h r=%0h dbz=%0b",
                         i, got.q, got.r, got.dbz, want.q, want.r, want.dbz);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_full_extremes();
        logic [W-1:0] tn[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] td[3] = '{32'd1, 32'hFFFF_FFFF, 32'd3};
        logic [W-1:0] n, d;
        int cyc, busy, want_cyc;
        res_t got, want;
        for (int i = 0; i < 11; i++) begin
            if (i < 3) begin
                n = tn[i];
                d = td[i];
            end else begin
                n = $urandom;
                d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(1, 255);
            end
            want_cyc = (d == 0 || n < d) ? 1 : W + 1;
            accept_req(n, d, 1'b1);
            wait_result(cyc, busy);
            n_cmp++;
            if (cyc != want_cyc) begin
                n_err++;
                $display("FAIL ext_latency[%0d]: out_valid in cycle %0d, want %0d", i, cyc, want_cyc);
            end
            got = observed();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL ext_result[%0d] %0h/%0h: got q=%0h r=%0h dbz=%0b, want q=%0h r=%0h dbz=%0b",
                         i, n, d, got.q, got.r, got.dbz, want.q, want.r, want.dbz);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ignored_request();
        int pulses, first_cyc;
        res_t got, want;
        pulses = 0;
        first_cyc = -1;
        accept_req(1000, 3, 1'b1);
        for (int c = 1; c <= 40; c++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    first_cyc = c;
                    got = observed();
                    want = sb.pop_front();
                    n_cmp++;
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL ignored_result: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=%0b",
                                 got.q, got.r, got.dbz, want.q, want.r, want.dbz);
                    end
                end
            end
            in_valid = (c >= 5 && c <= 10);
            dividend = 8;
            divisor  = 2;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL ignored_pulses: saw %0d out_valid pulses, want 1", pulses);
        end
        n_cmp++;
        if (first_cyc != W + 1) begin
            n_err++;
            $display("FAIL ignored_latency: out_valid in cycle %0d, want %0d", first_cyc, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, busy;
        res_t got, want;
        accept_req(50, 7, 1'b1);
        wait_result(cyc, busy);
        got = observed();
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL b2b_first: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=%0b",
                     got.q, got.r, got.dbz, want.q, want.r, want.dbz);
        end
        // Still in DONE: the next request is issued in this very cycle.
        accept_req(9, 0, 1'b1);
        got = observed();
        want = sb.pop_front();
        n_cmp++;
        if ({out_valid, got} !== {1'b1, want}) begin
            n_err++;
            $display("FAIL b2b_dbz: got ov=%0b q=%0h r=%0h dbz=%0b, want ov=1 q=%0h r=%0h dbz=%0b",
                     out_valid, got.q, got.r, got.dbz, want.q, want.r, want.dbz);
        end
        accept_req(3, 8, 1'b1);
        got = observed();
        want = sb.pop_front();
        n_cmp++;
        if ({out_valid, got} !== {1'b1, want}) begin
            n_err++;
            $display("FAIL b2b_fast: got ov=%0b q=%0h r=%0h dbz=%0b, want ov=1 q=%0h r=%0h dbz=%0b",
                     out_valid, got.q, got.r, got.dbz, want.q, want.r, want.dbz);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_end: out_valid=%0b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        int cyc, busy, pulses;
        res_t got, want;
        accept_req(100, 7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({quotient, remainder, div_by_zero, out_valid, in_ready} !== {{(2*W){1'b0}}, 3'b001}) begin
            n_err++;
            $display("FAIL midreset_state: got q=%0h r=%0h dbz=%0b ov=%0b ir=%0b, want 0 0 0 0 1",
                     quotient, remainder, div_by_zero, out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid === 1'b1) pulses++;
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL midreset_no_pulse: saw %0d out_valid pulses, want 0", pulses);
        end
        accept_req(50, 5, 1'b1);
        wait_result(cyc, busy);
        n_cmp++;
        if (cyc != W + 1) begin
            n_err++;
            $display("FAIL midreset_latency: out_valid in cycle %0d, want %0d", cyc, W + 1);
        end
        got = observed();
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL midreset_result: got q=%0d r=%0d dbz=%0b, want q=%0d r=%0d dbz=%0b",
                     got.q, got.r, got.dbz, want.q, want.r, want.dbz);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_full_path();
        test_div_by_zero();
        test_fast_path();
        test_full_extremes();
        test_ignored_request();
        test_back_to_back();
        test_reset_mid_op();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d results never seen, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
